// File: rtl/vec_pkg.sv
// Shared types for the vector memory stage: lane packing, FSM states, lane-index width.
package vec_pkg;

    localparam int VEC_N  = 16;
    localparam int VEC_M  = 16;
    localparam int VEC_AW = 16;
    localparam int LANE_W = $clog2(VEC_M);

    // Lane k occupies bits k*VEC_N +: VEC_N, the same packing the writeback select expects.
    typedef logic [VEC_M-1:0][VEC_N-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_LAST,
        STORE,
        DONE
    } state_t;

endpackage

// File: rtl/vec_addr_gen.sv
// Lane address accumulator: loads the base, then adds the latched stride once per issued lane.
module vec_addr_gen #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] acc;
    logic [AW-1:0] stride_q;

    // Accumulate modulo 2^AW; carry out of the top bit is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            stride_q <= '0;
        end else if (load) begin
            acc      <= base;
            stride_q <= stride;
        end else if (step) begin
            acc      <= acc + stride_q;
        end
    end

    assign addr = acc;

endmodule

// File: rtl/vec_mem_unit.sv
// Vector load/store unit: moves M lanes of N bits through a single-word synchronous memory port.
//
// Control handshake: start is sampled only while busy=0 (IDLE); the operands are
// latched on that edge. busy stays high from the next cycle until the done cycle
// inclusive; done is a single-cycle pulse and a new start is taken the cycle after it.
// A start seen while busy=1 is dropped without touching any latched operand.
module vec_mem_unit
    import vec_pkg::*;
#(
    parameter int N  = VEC_N,
    parameter int M  = VEC_M,
    parameter int AW = VEC_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                we,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       stride,
    input  logic [M-1:0][N-1:0] wdata_vec,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [N-1:0]        mem_wdata,
    input  logic [N-1:0]        mem_rdata,
    output logic [M-1:0][N-1:0] rdata_vec,
    output logic                busy,
    output logic                done,
    output state_t              fsm_state
);

    localparam int KW = $clog2(M);
    localparam logic [KW-1:0] LAST_LANE = KW'(M - 1);

    state_t               state;
    state_t               next_state;
    logic [KW-1:0]        k;
    logic [M-1:0][N-1:0]  wdata_q;
    logic [M-1:0][N-1:0]  rdata_q;
    logic                 accept;

    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: one lane per cycle, load adds one drain cycle for the last read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = we ? STORE : LOAD;
            LOAD:      if (k == LAST_LANE) next_state = LOAD_LAST;
            LOAD_LAST: next_state = DONE;
            STORE:     if (k == LAST_LANE) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Lane counter holds at the last lane so LOAD_LAST can index it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (accept) begin
            k <= '0;
        end else if ((state == LOAD || state == STORE) && k != LAST_LANE) begin
            k <= k + 1'b1;
        end
    end

    // Store source is snapshotted at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             wdata_q <= '0;
        else if (accept && we)  wdata_q <= wdata_vec;
    end

    // Read data arrives one cycle after its issue, so lane k-1 is captured while lane k issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state == LOAD && k != '0) begin
            rdata_q[k - 1'b1] <= mem_rdata;
        end else if (state == LOAD_LAST) begin
            rdata_q[LAST_LANE] <= mem_rdata;
        end
    end

    vec_addr_gen #(.AW(AW)) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (mem_re | mem_we),
        .base   (base_addr),
        .stride (stride),
        .addr   (mem_addr)
    );

    // Port strobes decode straight from state, so an async reset clears them immediately.
    always_comb begin
        mem_re    = (state == LOAD);
        mem_we    = (state == STORE);
        mem_wdata = '0;
        if (state == STORE) mem_wdata = wdata_q[k];
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    assign rdata_vec = rdata_q;
    assign fsm_state = state;

endmodule
